// File: rtl/approx_adder_error_monitor.sv
// Exhaustive error characterisation of a combinational approximate adder: sweeps every
// operand pair, compares against the exact sum and accumulates max/total error and mismatches.
module approx_adder_error_monitor #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = IN_W + 1,
  parameter int unsigned ET    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [2*IN_W-1:0]       stim,
  input  logic [OUT_W-1:0]        approx_in,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [OUT_W-1:0]        max_err,
  output logic [OUT_W+2*IN_W-1:0] err_sum,
  output logic [2*IN_W:0]         mismatch_cnt
);

  localparam int unsigned SW   = 2 * IN_W;
  localparam int unsigned SumW = OUT_W + SW;
  localparam int unsigned CntW = SW + 1;

  localparam logic [SW-1:0] StimLast = '1;
  localparam logic [SW-1:0] StimOne  = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     stim_q, stim_d;
  logic              s1_valid_q, s1_valid_d;
  logic [SW-1:0]     s1_stim_q, s1_stim_d;
  logic [OUT_W-1:0]  s1_approx_q, s1_approx_d;
  logic [OUT_W-1:0]  max_err_q, max_err_d;
  logic [SumW-1:0]   err_sum_q, err_sum_d;
  logic [CntW-1:0]   mis_cnt_q, mis_cnt_d;
  logic              pass_q, pass_d;

  // Stage 2 datapath: error of the captured vector and the updated accumulators.
  logic [IN_W-1:0]   op_a, op_b;
  logic [OUT_W-1:0]  exact;
  logic [OUT_W-1:0]  err;
  logic [OUT_W-1:0]  max_acc;
  logic [SumW-1:0]   sum_acc;
  logic [CntW-1:0]   cnt_acc;

  always_comb begin
    op_a    = s1_stim_q[IN_W-1:0];
    op_b    = s1_stim_q[SW-1:IN_W];
    exact   = {{(OUT_W-IN_W){1'b0}}, op_a} + {{(OUT_W-IN_W){1'b0}}, op_b};
    err     = (exact >= s1_approx_q) ? (exact - s1_approx_q) : (s1_approx_q - exact);
    max_acc = (err > max_err_q) ? err : max_err_q;
    sum_acc = err_sum_q + {{SW{1'b0}}, err};
    cnt_acc = mis_cnt_q + {{SW{1'b0}}, (err != '0)};
  end

  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    s1_valid_d  = 1'b0;
    s1_stim_d   = s1_stim_q;
    s1_approx_d = s1_approx_q;
    max_err_d   = max_err_q;
    err_sum_d   = err_sum_q;
    mis_cnt_d   = mis_cnt_q;
    pass_d      = pass_q;

    if (s1_valid_q) begin
      max_err_d = max_acc;
      err_sum_d = sum_acc;
      mis_cnt_d = cnt_acc;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          stim_d    = '0;
          max_err_d = '0;
          err_sum_d = '0;
          mis_cnt_d = '0;
          pass_d    = 1'b0;
        end
      end
      StRun: begin
        // The adder is combinational: approx_in belongs to the stim driven this cycle.
        s1_valid_d  = 1'b1;
        s1_stim_d   = stim_q;
        s1_approx_d = approx_in;
        if (stim_q != StimLast) begin
          stim_d = stim_q + StimOne;
        end else begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        // Last vector is accumulated on this edge, so judge pass on the updated maximum.
        state_d = StDone;
        pass_d  = (32'(max_acc) <= ET);
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      stim_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_stim_q   <= '0;
      s1_approx_q <= '0;
      max_err_q   <= '0;
      err_sum_q   <= '0;
      mis_cnt_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      s1_valid_q  <= s1_valid_d;
      s1_stim_q   <= s1_stim_d;
      s1_approx_q <= s1_approx_d;
      max_err_q   <= max_err_d;
      err_sum_q   <= err_sum_d;
      mis_cnt_q   <= mis_cnt_d;
      pass_q      <= pass_d;
    end
  end

  assign stim         = stim_q;
  assign busy         = (state_q == StRun) || (state_q == StFlush);
  assign done         = (state_q == StDone);
  assign pass         = pass_q;
  assign max_err      = max_err_q;
  assign err_sum      = err_sum_q;
  assign mismatch_cnt = mis_cnt_q;

endmodule

// File: doc/approx_adder_error_monitor.md
Name: approx_adder_error_monitor

Overview:
- Exhaustive error-characterisation stage for one approximate adder netlist.
- Drives every operand pair onto the adder's flat input bus, where stim[k] connects to in<k>.
- Captures the adder's flat output bus, where approx_in[k] connects from out<k>.
- Computes absolute error against an exact adder; accumulates worst-case error, total error and mismatch count; reports pass/fail against the error threshold. Sits directly upstream (stimulus) and downstream (checking) of the combinational approximate adder.

Parameters:
- IN_W, 2, width of each operand; the adder has 2*IN_W inputs.
- OUT_W, IN_W+1, adder output width.
- ET, 4, error threshold; pass requires max_err <= ET.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a characterisation run; sampled only in IDLE
- stim  output  2*IN_W  operand bus to the adder; a = stim[IN_W-1:0], b = stim[2*IN_W-1:IN_W]
- approx_in  input  OUT_W  adder result, unsigned, bit 0 = out0
- busy  output  1  high in RUN and FLUSH
- done  output  1  one-cycle pulse; results final
- pass  output  1  max_err <= ET; valid when done, held until next start
- max_err  output  OUT_W  largest |exact - approx|
- err_sum  output  OUT_W+2*IN_W  sum of |exact - approx| over all vectors
- mismatch_cnt  output  2*IN_W+1  number of vectors with nonzero error

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, stim=0, busy=0, done=0, pass=0, max_err=0, err_sum=0, mismatch_cnt=0, stage valids=0. Reset wins over every other event, including mid-run; the run is abandoned with no done pulse.
- N = 2^(2*IN_W) vectors.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start=1 at edge E0 -> RUN; stim=0; max_err, err_sum, mismatch_cnt and pass cleared.
  - start=0 -> stay in IDLE; results hold.
- RUN:
  - Each edge: stage-1 registers capture (stim, approx_in, valid=1).
  - If stim != N-1: stim increments.
  - Else: stim holds; state -> FLUSH.
  - The adder is combinational, so approx_in corresponds to the stim value driven during the same cycle.
- Stage 2 (edge after capture, when stage-1 valid):
  - exact = a + b, OUT_W bits, no overflow possible.
  - err = |exact - approx|, OUT_W bits.
  - max_err = max(max_err, err).
  - err_sum += err; cannot overflow at the declared width.
  - mismatch_cnt += (err != 0).
- FLUSH: one edge drains stage 2 (accumulates vector N-1); stage-1 valid cleared; state -> DONE.
- DONE:
  - done=1 and pass = (max_err <= ET) for exactly one cycle.
  - Next edge -> IDLE; done=0.
- Timing: busy rises in the cycle after E0. done is high in the cycle after edge E(N+1); for defaults this is the cycle after E17.
- start while busy or in DONE: ignored, no restart.
- start held high continuously: a new run begins on the first IDLE edge after DONE; results are cleared at that edge.
- Outputs stay stable in IDLE; stim returns to 0 only on the next start or reset.

Test Plan:
- Exact model (approx_in = a+b), start pulse at E0 -> stim steps 0..15; done in the cycle after E17; max_err=0, err_sum=0, mismatch_cnt=0, pass=1.
- Constant approx_in=0 -> max_err=6, err_sum=48, mismatch_cnt=15, pass=0 (ET=4).
- approx_in = exact XOR 1 -> max_err=1, err_sum=16, mismatch_cnt=16, pass=1.
- rst asserted at stim=7 during RUN -> the next cycle shows all outputs at reset values and no done pulse; a subsequent start completes a normal run with correct totals.
- start pulsed at stim=5 while busy -> ignored; vector sequence and totals identical to the uninterrupted run.
- Two back-to-back runs (constant-zero model, then exact model, start held high) -> second run reports 0/0/0 and pass=1; no carry-over from the first run.
